// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM control unit: opcodes, control codes, condition codes,
// the FSM state enum and the decoder output bundle.
package arm_ctrl_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] ALUSRC_IMM = 2'b01;

  localparam logic [1:0] REGSRC_NONE  = 2'b00;
  localparam logic [1:0] REGSRC_PC    = 2'b01;
  localparam logic [1:0] REGSRC_STORE = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic [1:0] {
    RESET = 2'b00,
    RUN   = 2'b01,
    HALT  = 2'b10
  } state_t;

  typedef struct packed {
    logic       reg_w;
    logic       mem_w;
    logic       mem_to_reg;
    logic       branch;
    logic       no_write;
    logic       s_bit;
    logic       undef;
    logic [1:0] alu_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [1:0] alu_ctl;
  } ctrl_t;

  // nzcv = {N, Z, C, V}; the reserved code never executes.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cond_logic.sv
// Architectural NZCV flags with split NZ/CV write enables and condition evaluation.
// Zero-cycle CondEx from stored flags; flags update on the clock edge, reset wins over writes.
module cond_logic
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       run,
  output logic       cond_ex,
  output logic [3:0] flags
);

  logic [1:0] nz;
  logic [1:0] cv;
  logic [1:0] wen;

  assign flags   = {nz, cv};
  assign cond_ex = cond_holds(cond, flags);
  assign wen     = flag_w & {2{cond_ex & run}};

  always_ff @(posedge clk) begin
    if (reset) begin
      nz <= 2'b00;
      cv <= 2'b00;
    end else begin
      if (wen[1]) nz <= alu_flags[3:2];
      if (wen[0]) cv <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/arm_control_unit.sv
// Single-cycle ARM control unit: decode, condition gating and reset/run/halt FSM, zero-cycle latency.
// ARM_CTRL_UNDEF_TRAP_EN makes undefined instructions halt the FSM until reset.
module arm_control_unit
  import arm_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic [1:0]  ALUSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  Flags,
  output logic        Halted
);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cond;
  logic       unused_bits;

  assign op          = Instr[27:26];
  assign funct       = Instr[25:20];
  assign rd          = Instr[15:12];
  assign cond        = Instr[31:28];
  assign unused_bits = ^{Instr[19:16], Instr[11:0]};

  state_t state;
  state_t state_nxt;
  logic   run;
  ctrl_t  dec;
  ctrl_t  eff;
  logic   cond_ex;
  logic   pcs;
  logic [1:0] flag_w;

  assign run = (state == RUN);

  always_comb begin
    dec = '0;
    case (op)
      OP_DP: begin
        dec.alu_src = {1'b0, funct[5]};
        dec.imm_src = IMM_DP;
        dec.reg_src = REGSRC_NONE;
        dec.reg_w   = 1'b1;
        dec.s_bit   = funct[0];
        case (funct[4:1])
          CMD_ADD: dec.alu_ctl = ALU_ADD;
          CMD_SUB: dec.alu_ctl = ALU_SUB;
          CMD_AND: dec.alu_ctl = ALU_AND;
          CMD_ORR: dec.alu_ctl = ALU_ORR;
          CMD_CMP: begin
            dec.alu_ctl  = ALU_SUB;
            dec.s_bit    = 1'b1;
            dec.no_write = 1'b1;
          end
          default: dec.undef = 1'b1;
        endcase
      end
      OP_MEM: begin
        dec.alu_src = ALUSRC_IMM;
        dec.imm_src = IMM_MEM;
        dec.alu_ctl = ALU_ADD;
        if (funct[0]) begin
          dec.reg_w      = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.reg_src    = REGSRC_NONE;
        end else begin
          dec.mem_w   = 1'b1;
          dec.reg_src = REGSRC_STORE;
        end
      end
      OP_BR: begin
        dec.imm_src = IMM_BR;
        dec.alu_src = ALUSRC_IMM;
        dec.reg_src = REGSRC_PC;
        dec.alu_ctl = ALU_ADD;
        dec.branch  = 1'b1;
      end
      default: dec.undef = 1'b1;
    endcase
    if (cond == COND_NV) dec.undef = 1'b1;
  end

  // Outside RUN, and for undefined encodings, everything collapses to an all-zero NOP.
  always_comb begin
    eff = dec;
    if (dec.undef || !run) eff = '0;
  end

  assign pcs    = ((rd == 4'd15) & eff.reg_w) | eff.branch;
  assign flag_w = {eff.s_bit, eff.s_bit & ((eff.alu_ctl == ALU_ADD) | (eff.alu_ctl == ALU_SUB))};

  cond_logic u_cond_logic (
    .clk       (CLK),
    .reset     (reset),
    .cond      (cond),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w),
    .run       (run),
    .cond_ex   (cond_ex),
    .flags     (Flags)
  );

  assign PCSrc      = pcs & cond_ex & run;
  assign RegWrite   = eff.reg_w & cond_ex & ~eff.no_write & run;
  assign MemWrite   = eff.mem_w & cond_ex & run;
  assign MemtoReg   = eff.mem_to_reg;
  assign ALUSrc     = eff.alu_src;
  assign ImmSrc     = eff.imm_src;
  assign RegSrc     = eff.reg_src;
  assign ALUControl = eff.alu_ctl;

  always_ff @(posedge CLK) begin
    if (reset) state <= RESET;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESET: state_nxt = RUN;
      RUN: begin
`ifdef ARM_CTRL_UNDEF_TRAP_EN
        if (dec.undef) state_nxt = HALT;
`endif
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RESET;
    endcase
  end

`ifdef ARM_CTRL_UNDEF_TRAP_EN
  assign Halted = (state == HALT);
`else
  assign Halted = 1'b0;
`endif

endmodule

// File: tb/tb_arm_control_unit.sv
// Self-checking bench for arm_control_unit: directed instruction scenarios followed by
// randomized instruction streams compared against an instruction-level reference model.
module tb_arm_control_unit;

  logic        CLK;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCSrc, RegWrite, MemWrite, MemtoReg, Halted;
  logic [1:0]  ALUSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0]  Flags;

  arm_control_unit dut (
    .CLK        (CLK),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .MemtoReg   (MemtoReg),
    .ALUSrc     (ALUSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .Flags      (Flags),
    .Halted     (Halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       pcsrc;
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic [1:0] alusrc;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic [1:0] aluctl;
    logic       upd_nz;
    logic       upd_cv;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: 0 = reset cycle, 1 = running, 2 = halted.
  int          m_phase;
  logic [3:0]  m_flags;
  logic [31:0] cur_ins;
  logic [3:0]  cur_af;
  logic        cur_rst;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_undef(input logic [31:0] ins);
    logic [3:0] cmd;
    cmd = ins[24:21];
    if (ins[31:28] == 4'hF) return 1'b1;
    if (ins[27:26] == 2'd3) return 1'b1;
    if (ins[27:26] == 2'd0)
      return !(cmd == 4'd4 || cmd == 4'd2 || cmd == 4'd0 || cmd == 4'd12 || cmd == 4'd10);
    return 1'b0;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [3:0] fl, input int phase);
    exp_t e;
    bit   ok, s;
    logic [3:0] cmd;
    e = '0;
    if (phase != 1 || is_undef(ins)) return e;
    ok  = cond_pass(ins[31:28], fl);
    cmd = ins[24:21];
    case (ins[27:26])
      2'd0: begin
        case (cmd)
          4'd4:    e.aluctl = 2'd0;
          4'd2:    e.aluctl = 2'd1;
          4'd0:    e.aluctl = 2'd2;
          4'd12:   e.aluctl = 2'd3;
          default: e.aluctl = 2'd1;
        endcase
        e.alusrc   = {1'b0, ins[25]};
        s          = ins[20] || (cmd == 4'd10);
        e.regwrite = ok && (cmd != 4'd10);
        e.pcsrc    = ok && (ins[15:12] == 4'd15);
        e.upd_nz   = ok && s;
        e.upd_cv   = ok && s && (e.aluctl < 2'd2);
      end
      2'd1: begin
        e.alusrc = 2'd1;
        e.immsrc = 2'd1;
        if (ins[20]) begin
          e.regwrite = ok;
          e.memtoreg = 1'b1;
          e.pcsrc    = ok && (ins[15:12] == 4'd15);
        end else begin
          e.memwrite = ok;
          e.regsrc   = 2'd2;
        end
      end
      default: begin
        e.immsrc = 2'd2;
        e.alusrc = 2'd1;
        e.regsrc = 2'd1;
        e.pcsrc  = ok;
      end
    endcase
    return e;
  endfunction

  task automatic apply(input logic [31:0] ins, input logic [3:0] af, input logic rst);
    exp_t e;
    Instr    = ins;
    ALUFlags = af;
    reset    = rst;
    cur_ins  = ins;
    cur_af   = af;
    cur_rst  = rst;
    #2;
    e = model(ins, m_flags, m_phase);
    check_eq("PCSrc",      4'(PCSrc),      4'(e.pcsrc));
    check_eq("RegWrite",   4'(RegWrite),   4'(e.regwrite));
    check_eq("MemWrite",   4'(MemWrite),   4'(e.memwrite));
    check_eq("MemtoReg",   4'(MemtoReg),   4'(e.memtoreg));
    check_eq("ALUSrc",     4'(ALUSrc),     4'(e.alusrc));
    check_eq("ImmSrc",     4'(ImmSrc),     4'(e.immsrc));
    check_eq("RegSrc",     4'(RegSrc),     4'(e.regsrc));
    check_eq("ALUControl", 4'(ALUControl), 4'(e.aluctl));
    check_eq("Flags",      Flags,          m_flags);
    check_eq("Halted",     4'(Halted),     4'(m_phase == 2));
  endtask

  task automatic tick();
    exp_t e;
    bit   und;
    e   = model(cur_ins, m_flags, m_phase);
    und = is_undef(cur_ins);
    if (cur_rst) begin
      m_flags = 4'h0;
      m_phase = 0;
    end else begin
      if (e.upd_nz) m_flags[3:2] = cur_af[3:2];
      if (e.upd_cv) m_flags[1:0] = cur_af[1:0];
      case (m_phase)
        0: m_phase = 1;
        1: begin
`ifdef ARM_CTRL_UNDEF_TRAP_EN
          if (und) m_phase = 2;
`endif
        end
        default: ;
      endcase
    end
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [3:0]  cmd;
    int          kind;
    w    = $urandom;
    kind = $urandom_range(0, 19);
    if (kind < 19) w[31:28] = 4'($urandom_range(0, 14));
    if (kind < 8) begin
      w[27:26] = 2'd0;
      case ($urandom_range(0, 5))
        0: cmd = 4'd4;
        1: cmd = 4'd2;
        2: cmd = 4'd0;
        3: cmd = 4'd12;
        4: cmd = 4'd10;
        default: cmd = 4'($urandom_range(0, 15));
      endcase
      w[24:21] = cmd;
    end else if (kind < 13) begin
      w[27:26] = 2'd1;
    end else if (kind < 17) begin
      w[27:26] = 2'd2;
    end
    return w;
  endfunction

  localparam logic [31:0] I_ADD = 32'hE2821005;
  localparam logic [31:0] I_CMP = 32'hE1510001;
  localparam logic [31:0] I_BEQ = 32'h0A000002;
  localparam logic [31:0] I_BNE = 32'h1A000002;
  localparam logic [31:0] I_STR = 32'hE5843008;
  localparam logic [31:0] I_LDR = 32'hE5943008;
  localparam logic [31:0] I_UND = 32'hEC000000;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    Instr    = 32'h0;
    ALUFlags = 4'h0;
    @(posedge CLK);
    #1;
    m_phase = 0;
    m_flags = 4'h0;

    apply(I_ADD, 4'h0, 1'b1);
    check_eq("rst_regwrite", 4'(RegWrite), 4'h0);
    check_eq("rst_flags", Flags, 4'h0);
    tick();
    apply(I_ADD, 4'h0, 1'b0);
    check_eq("first_cycle_regwrite", 4'(RegWrite), 4'h0);
    tick();

    apply(I_ADD, 4'h0, 1'b0);
    check_eq("add_regwrite", 4'(RegWrite), 4'h1);
    check_eq("add_alusrc", 4'(ALUSrc), 4'h1);
    check_eq("add_immsrc", 4'(ImmSrc), 4'h0);
    check_eq("add_aluctl", 4'(ALUControl), 4'h0);
    check_eq("add_pcsrc", 4'(PCSrc), 4'h0);
    check_eq("add_memwrite", 4'(MemWrite), 4'h0);
    tick();

    apply(I_CMP, 4'b0100, 1'b0);
    check_eq("cmp_regwrite", 4'(RegWrite), 4'h0);
    check_eq("cmp_aluctl", 4'(ALUControl), 4'h1);
    tick();
    check_eq("cmp_flags", Flags, 4'b0100);

    apply(I_BEQ, 4'h0, 1'b0);
    check_eq("beq_pcsrc", 4'(PCSrc), 4'h1);
    check_eq("beq_immsrc", 4'(ImmSrc), 4'h2);
    check_eq("beq_regsrc", 4'(RegSrc), 4'h1);
    tick();

    apply(I_BNE, 4'b1011, 1'b0);
    check_eq("bne_pcsrc", 4'(PCSrc), 4'h0);
    tick();
    check_eq("bne_flags", Flags, 4'b0100);

    apply(I_STR, 4'h0, 1'b0);
    check_eq("str_memwrite", 4'(MemWrite), 4'h1);
    check_eq("str_regwrite", 4'(RegWrite), 4'h0);
    check_eq("str_regsrc", 4'(RegSrc), 4'h2);
    check_eq("str_immsrc", 4'(ImmSrc), 4'h1);
    tick();
    apply(I_LDR, 4'h0, 1'b0);
    check_eq("ldr_regwrite", 4'(RegWrite), 4'h1);
    check_eq("ldr_memtoreg", 4'(MemtoReg), 4'h1);
    tick();

    apply(I_CMP, 4'hF, 1'b0);
    tick();
    check_eq("flags_all_set", Flags, 4'hF);
    apply(I_CMP, 4'b0110, 1'b1);
    tick();
    check_eq("reset_clears_flags", Flags, 4'h0);
    apply(I_ADD, 4'h0, 1'b0);
    check_eq("post_reset_regwrite", 4'(RegWrite), 4'h0);
    tick();

    apply(I_UND, 4'h0, 1'b0);
    check_eq("undef_regwrite", 4'(RegWrite), 4'h0);
    tick();
    apply(I_ADD, 4'h0, 1'b0);
`ifdef ARM_CTRL_UNDEF_TRAP_EN
    check_eq("trap_halted", 4'(Halted), 4'h1);
    check_eq("trap_regwrite", 4'(RegWrite), 4'h0);
`else
    check_eq("nop_halted", 4'(Halted), 4'h0);
    check_eq("nop_regwrite", 4'(RegWrite), 4'h1);
`endif
    tick();
    apply(I_ADD, 4'h0, 1'b1);
    tick();

    for (int i = 0; i < 600; i++) begin
      apply(rand_instr(), 4'($urandom_range(0, 15)), ($urandom_range(0, 29) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
